// File: rtl/pixel_unpack_pkg.sv
// Shared types, mode constants and pixel-selection helpers for the pixel word unpacker.
package pixel_unpack_pkg;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic MODE_PAR = 1'b0;
    localparam logic MODE_SER = 1'b1;

    // Upper bound on word width the generic helper can carry.
    localparam int MAX_WORD_W = 512;

    function automatic int idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Pixel k of a word; msb_first maps pixel 0 to the top lane.
    function automatic logic [MAX_WORD_W-1:0] pix_sel(input logic [MAX_WORD_W-1:0] word,
                                                      input int k, input int pix_w,
                                                      input int lanes, input logic msb_first);
        int lane;
        lane = msb_first ? (lanes - 1 - k) : k;
        return (word >> (lane * pix_w)) & ({MAX_WORD_W{1'b1}} >> (MAX_WORD_W - pix_w));
    endfunction

endpackage

// File: rtl/pixel_word_unpacker_if.sv
// Word-in / pixel-out handshake bundle for the pixel word unpacker.
interface pixel_word_unpacker_if
    import pixel_unpack_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int PIX_W  = 8
);
    localparam int LANES = WORD_W / PIX_W;
    localparam int IDX_W = idx_w(LANES);

    logic              mode;
    logic              msb_first;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              out_ready;

    modport master (
        output mode, msb_first, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  mode, msb_first, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/pixel_lane_mux.sv
// Combinational selector: picks pixel idx out of a packed word with lane order applied.
module pixel_lane_mux #(
    parameter int WORD_W = 32,
    parameter int PIX_W  = 8,
    parameter int IDX_W  = 2
) (
    input  logic [WORD_W-1:0] word,
    input  logic [IDX_W-1:0]  idx,
    input  logic              msb_first,
    output logic [PIX_W-1:0]  pix
);
    localparam int LANES = WORD_W / PIX_W;

    int lane;

    always_comb begin
        lane = msb_first ? (LANES - 1 - int'(idx)) : int'(idx);
        pix  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lane == k) pix = word[k*PIX_W +: PIX_W];
        end
    end
endmodule

// File: rtl/pixel_word_unpacker.sv
// Unpacks BRAM words into pixels, either all lanes in one beat or one pixel per beat.
module pixel_word_unpacker
    import pixel_unpack_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int PIX_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pixel_word_unpacker_if.slave  bus
);
    localparam int LANES = WORD_W / PIX_W;
    localparam int IDX_W = idx_w(LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    state_t            state;
    logic [WORD_W-1:0] word_q;
    logic              mode_q;
    logic              order_q;
    logic [IDX_W-1:0]  idx_q;

    logic              last;
    logic              accept;
    logic              beat;
    logic [WORD_W-1:0] par_word;
    logic [PIX_W-1:0]  ser_pix;

    assign last   = (state == FULL) && ((mode_q == MODE_PAR) || (idx_q == LAST_IDX));
    // Ready passes through on the final beat so back-to-back words have no bubble.
    assign bus.in_ready = rst_n && ((state == EMPTY) || (bus.out_ready && last));
    assign accept = bus.in_valid && bus.in_ready;
    assign beat   = bus.out_valid && bus.out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_par
        assign par_word[i*PIX_W +: PIX_W] =
            PIX_W'(pix_sel(MAX_WORD_W'(word_q), i, PIX_W, LANES, order_q));
    end

    pixel_lane_mux #(
        .WORD_W (WORD_W),
        .PIX_W  (PIX_W),
        .IDX_W  (IDX_W)
    ) u_lane_mux (
        .word      (word_q),
        .idx       (idx_q),
        .msb_first (order_q),
        .pix       (ser_pix)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            word_q  <= '0;
            mode_q  <= MODE_PAR;
            order_q <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            state   <= FULL;
            word_q  <= bus.in_data;
            mode_q  <= bus.mode;
            order_q <= bus.msb_first;
            idx_q   <= '0;
        end else if (beat) begin
            if (last) state <= EMPTY;
            else      idx_q <= idx_q + 1'b1;
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_last  = last;
    assign bus.out_idx   = ((state == FULL) && (mode_q == MODE_SER)) ? idx_q : '0;
    assign bus.out_data  = (state != FULL)     ? '0 :
                           (mode_q == MODE_SER) ? WORD_W'(ser_pix) : par_word;
endmodule

// File: tb/tb_pixel_word_unpacker.sv
// Bench: default 32/8 unpacker and a 24/12 unpacker driven in lockstep against a beat-list model.
module tb_pixel_word_unpacker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pixel_word_unpacker_if #(.WORD_W(32), .PIX_W(8))  b0 ();
    pixel_word_unpacker_if #(.WORD_W(24), .PIX_W(12)) b1 ();

    pixel_word_unpacker #(.WORD_W(32), .PIX_W(8)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0.slave)
    );

    pixel_word_unpacker #(.WORD_W(24), .PIX_W(12)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1.slave)
    );

    typedef struct {
        logic [31:0] d;
        int          idx;
        logic        last;
    } beat_t;

    beat_t q0[$];
    beat_t q1[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pix(input logic [31:0] w, input int k, input int pw,
                                        input int lanes, input logic msb);
        int lane;
        lane = msb ? (lanes - 1 - k) : k;
        return (w >> (lane * pw)) & ((32'd1 << pw) - 32'd1);
    endfunction

    // Queue holds the beats still owed for the word in flight.
    task automatic side(ref beat_t q[$], input string nm, input int pw, input int lanes,
                        input logic rdy, input logic vld, input logic [31:0] od,
                        input int oi, input logic ol, input logic iv, input logic [31:0] w,
                        input logic md, input logic msb, input logic ordy);
        logic  er;
        beat_t b;
        er = (q.size() == 0) || (ordy && (q.size() == 1));
        check({nm, "_in_ready"}, 32'(rdy), 32'(er));
        check({nm, "_out_valid"}, 32'(vld), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check({nm, "_out_data"}, od, q[0].d);
            check({nm, "_out_idx"}, 32'(oi), 32'(q[0].idx));
            check({nm, "_out_last"}, 32'(ol), 32'(q[0].last));
            if (ordy) void'(q.pop_front());
        end
        if (iv && er) begin
            if (md == 1'b0) begin
                b.d = '0;
                for (int k = 0; k < lanes; k++) b.d |= pix(w, k, pw, lanes, msb) << (k * pw);
                b.idx = 0;
                b.last = 1'b1;
                q.push_back(b);
            end else begin
                for (int k = 0; k < lanes; k++) begin
                    b.d = pix(w, k, pw, lanes, msb);
                    b.idx = k;
                    b.last = (k == lanes - 1);
                    q.push_back(b);
                end
            end
        end
    endtask

    task automatic cycle(input logic iv, input logic [31:0] dat, input logic md,
                         input logic msb, input logic ordy);
        @(negedge clk);
        b0.in_valid = iv;  b0.in_data = dat;        b0.mode = md; b0.msb_first = msb; b0.out_ready = ordy;
        b1.in_valid = iv;  b1.in_data = dat[23:0];  b1.mode = md; b1.msb_first = msb; b1.out_ready = ordy;
        #1;
        side(q0, "p", 8, 4, b0.in_ready, b0.out_valid, b0.out_data, int'(b0.out_idx),
             b0.out_last, iv, dat, md, msb, ordy);
        side(q1, "s", 12, 2, b1.in_ready, b1.out_valid, {8'h0, b1.out_data}, int'(b1.out_idx),
             b1.out_last, iv, {8'h0, dat[23:0]}, md, msb, ordy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        b0.in_valid = 0; b0.in_data = '0; b0.mode = 0; b0.msb_first = 0; b0.out_ready = 1;
        b1.in_valid = 0; b1.in_data = '0; b1.mode = 0; b1.msb_first = 0; b1.out_ready = 1;
        #2;
        check("rst_out_valid", 32'(b0.out_valid), 32'h0);
        check("rst_out_data", b0.out_data, 32'h0);
        check("rst_in_ready", 32'(b0.in_ready), 32'h0);
        check("rst_out_idx", 32'(b0.out_idx), 32'h0);
        check("rst_out_last", 32'(b0.out_last), 32'h0);
        check("rst_s_out_valid", 32'(b1.out_valid), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Parallel, both lane orders, back to back.
        cycle(1'b1, 32'hDDCCBBAA, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'hDDCCBBAA, 1'b0, 1'b1, 1'b1);
        check("par_lsb_data", b0.out_data, 32'hDDCCBBAA);
        check("par_lsb_last", 32'(b0.out_last), 32'h1);
        idle(1);
        check("par_msb_data", b0.out_data, 32'hAABBCCDD);
        idle(2);

        // Serial with a new word taken on the last beat.
        cycle(1'b1, 32'h44332211, 1'b1, 1'b0, 1'b1);
        idle(1);
        check("ser_b0", b0.out_data, 32'h11);
        idle(1);
        check("ser_b1", b0.out_data, 32'h22);
        check("ser_b1_last", 32'(b0.out_last), 32'h0);
        idle(1);
        check("ser_b2_idx", 32'(b0.out_idx), 32'h2);
        cycle(1'b1, 32'h88776655, 1'b1, 1'b0, 1'b1);
        check("ser_b3", b0.out_data, 32'h44);
        check("ser_b3_last", 32'(b0.out_last), 32'h1);
        check("ser_b3_ready", 32'(b0.in_ready), 32'h1);
        idle(1);
        check("ser_nobubble", b0.out_data, 32'h55);
        idle(5);

        // 24/12 serial.
        cycle(1'b1, 32'h00ABC123, 1'b1, 1'b0, 1'b1);
        idle(1);
        check("w24_b0", {8'h0, b1.out_data}, 32'h123);
        check("w24_b0_last", 32'(b1.out_last), 32'h0);
        idle(1);
        check("w24_b1", {8'h0, b1.out_data}, 32'hABC);
        check("w24_b1_last", 32'(b1.out_last), 32'h1);
        idle(5);

        // Back-pressure on beat 2.
        cycle(1'b1, 32'h44332211, 1'b1, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            check("bp_data", b0.out_data, 32'h33);
            check("bp_idx", 32'(b0.out_idx), 32'h2);
            check("bp_ready", 32'(b0.in_ready), 32'h0);
        end
        idle(5);

        // Mode flips during beat 1; in-flight word finishes serially.
        cycle(1'b1, 32'hA4A3A2A1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("mc_still_serial", b0.out_data, 32'hA2);
        idle(1);
        cycle(1'b1, 32'hB4B3B2B1, 1'b0, 1'b0, 1'b1);
        idle(1);
        check("mc_parallel", b0.out_data, 32'hB4B3B2B1);
        check("mc_par_last", 32'(b0.out_last), 32'h1);
        idle(3);

        // Reset in the middle of a serial word.
        cycle(1'b1, 32'h44332211, 1'b1, 1'b0, 1'b1);
        idle(2);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 32'(b0.out_valid), 32'h0);
        check("mrst_out_data", b0.out_data, 32'h0);
        check("mrst_in_ready", 32'(b0.in_ready), 32'h0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 2) != 0, $urandom, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0);
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
